// File: rtl/if_id_buffer_if.sv
// -----------------------------------------------------------------------------
// if_id_buffer_if
// Handshake bundle between the fetch stage, the IF/ID buffer and decode.
//   Fetch side  : in_valid, in_instr, in_pc_inc2 -> buffer ; in_ready <- buffer
//   Decode side : out_valid, out_instr, out_pc_inc2 <- buffer ; out_ready -> buffer
//   Control     : flush -> buffer ; halt_seen, count <- buffer
// Modports: master = fetch/decode/control side, slave = the buffer itself.
// -----------------------------------------------------------------------------
interface if_id_buffer_if #(
   parameter int CNT_W = 2
);
   logic             in_valid;
   logic [15:0]      in_instr;
   logic [15:0]      in_pc_inc2;
   logic             in_ready;
   logic             out_valid;
   logic [15:0]      out_instr;
   logic [15:0]      out_pc_inc2;
   logic             out_ready;
   logic             flush;
   logic             halt_seen;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_instr, in_pc_inc2, out_ready, flush,
      input  in_ready, out_valid, out_instr, out_pc_inc2, halt_seen, count
   );

   modport slave (
      input  in_valid, in_instr, in_pc_inc2, out_ready, flush,
      output in_ready, out_valid, out_instr, out_pc_inc2, halt_seen, count
   );
endinterface

// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
// In-order FIFO of {instr, pc_inc2} pairs decoupling fetch from decode.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - if_id_buffer_if.slave: fetch push handshake, decode pop handshake,
//          synchronous flush, halt_seen flag and occupancy count
// Outputs are taken from registered state only: no in->out bypass, and
// in_ready never looks at out_ready, so a full buffer cannot pass through.
// Once a HALT (opcode 5'b00000) is accepted, further pushes are refused until
// flush or reset; the HALT itself still drains to decode.
// -----------------------------------------------------------------------------
module if_id_buffer #(
   parameter int          DEPTH     = 2,
   parameter int          CNT_W     = 2,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic          clk,
   input  logic          rst,
   if_id_buffer_if.slave bus
);
   // Pointers are one bit narrower than the count: DEPTH is a power of two,
   // so they wrap naturally and count disambiguates full from empty.
   localparam int PTR_W = CNT_W - 1;

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             halt_q, halt_d;
   logic [15:0]      instr_q [DEPTH];
   logic [15:0]      pc_q    [DEPTH];

   logic full, empty, in_ready, push, pop, wr_en;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = ~full & ~halt_q;
   assign push     = bus.in_valid & in_ready;
   assign pop      = ~empty & bus.out_ready;
   // A flush discards a concurrent push, so don't touch storage either.
   assign wr_en    = push & ~bus.flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      halt_d   = halt_q;
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         halt_d   = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (push && bus.in_instr[15:11] == 5'b00000) halt_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         halt_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         halt_q   <= halt_d;
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         instr_q[wr_ptr_q] <= bus.in_instr;
         pc_q[wr_ptr_q]    <= bus.in_pc_inc2;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = ~empty;
   assign bus.out_instr   = empty ? NOP_INSTR : instr_q[rd_ptr_q];
   assign bus.out_pc_inc2 = empty ? 16'h0000  : pc_q[rd_ptr_q];
   assign bus.halt_seen   = halt_q;
   assign bus.count       = count_q;
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer (DEPTH=2, CNT_W=2, NOP=16'h0800).
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_if_id_buffer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   if_id_buffer_if #(.CNT_W(2)) bus ();

   if_id_buffer #(.DEPTH(2), .CNT_W(2), .NOP_INSTR(16'h0800)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid   = 1'b0;
      bus.in_instr   = 16'hFFFF;
      bus.in_pc_inc2 = 16'h0000;
      bus.out_ready  = 1'b0;
      bus.flush      = 1'b0;
   endtask

   task automatic push(input logic [15:0] ins, input logic [15:0] pc);
      bus.in_valid   = 1'b1;
      bus.in_instr   = ins;
      bus.in_pc_inc2 = pc;
      tick();
      bus.in_valid   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid   = 1'($urandom);
         bus.in_instr   = 16'($urandom);
         bus.in_pc_inc2 = 16'($urandom);
         bus.out_ready  = 1'($urandom);
         bus.flush      = 1'b0;
         tick();
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out_instr !== 16'h0800 || bus.count !== 2'd0 ||
             bus.out_pc_inc2 !== 16'h0000 || bus.halt_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b i=%h pc=%h c=%0d h=%b exp v=0 i=0800 pc=0000 c=0 h=0",
                     bus.out_valid, bus.out_instr, bus.out_pc_inc2, bus.count, bus.halt_seen);
         end
      end
      idle();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
      end
   endtask

   task automatic test_fill_drain();
      idle();
      push(16'h1111, 16'h0002);
      checks++;
      if (bus.count !== 2'd1 || bus.out_valid !== 1'b1 || bus.out_instr !== 16'h1111) begin
         errors++; $display("FAIL fill_one got c=%0d v=%b i=%h exp c=1 v=1 i=1111",
                            bus.count, bus.out_valid, bus.out_instr);
      end
      push(16'h2222, 16'h0004);
      checks++;
      if (bus.count !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_instr !== 16'h1111) begin
         errors++; $display("FAIL fill_full got c=%0d rdy=%b i=%h exp c=2 rdy=0 i=1111",
                            bus.count, bus.in_ready, bus.out_instr);
      end
      // offer while full: must be refused
      push(16'h9999, 16'h0006);
      checks++;
      if (bus.count !== 2'd2 || bus.out_instr !== 16'h1111) begin
         errors++; $display("FAIL full_hold got c=%0d i=%h exp c=2 i=1111", bus.count, bus.out_instr);
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.out_instr !== 16'h1111 || bus.out_pc_inc2 !== 16'h0002) begin
         errors++; $display("FAIL drain_a got %h/%h exp 1111/0002", bus.out_instr, bus.out_pc_inc2);
      end
      tick();
      checks++;
      if (bus.out_instr !== 16'h2222 || bus.out_pc_inc2 !== 16'h0004 || bus.count !== 2'd1) begin
         errors++; $display("FAIL drain_b got %h/%h c=%0d exp 2222/0004 c=1",
                            bus.out_instr, bus.out_pc_inc2, bus.count);
      end
      tick();
      checks++;
      if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_instr !== 16'h0800) begin
         errors++; $display("FAIL drain_empty got c=%0d v=%b i=%h exp c=0 v=0 i=0800",
                            bus.count, bus.out_valid, bus.out_instr);
      end
      // empty with out_ready: nothing happens
      tick();
      checks++;
      if (bus.count !== 2'd0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL empty_pop got c=%0d rdy=%b exp c=0 rdy=1", bus.count, bus.in_ready);
      end
      idle();
   endtask

   task automatic test_streaming();
      logic [15:0] exp_i;
      idle();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_instr   = 16'h4000 + 16'(i);
         bus.in_pc_inc2 = 16'(2 * i + 2);
         #1;
         if (i > 0) begin
            exp_i = 16'h4000 + 16'(i - 1);
            checks++;
            if (bus.out_instr !== exp_i || bus.out_pc_inc2 !== 16'(2 * i) || bus.count !== 2'd1) begin
               errors++; $display("FAIL stream_%0d got %h/%h c=%0d exp %h/%h c=1",
                                  i, bus.out_instr, bus.out_pc_inc2, bus.count, exp_i, 16'(2 * i));
            end
         end
         tick();
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_instr !== 16'h4013 || bus.count !== 2'd1) begin
         errors++; $display("FAIL stream_last got %h c=%0d exp 4013 c=1", bus.out_instr, bus.count);
      end
      tick();
      checks++;
      if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL stream_end got c=%0d v=%b exp c=0 v=0", bus.count, bus.out_valid);
      end
      idle();
   endtask

   task automatic test_flush();
      idle();
      push(16'h5555, 16'h0010);
      push(16'h6666, 16'h0012);
      bus.flush      = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_instr   = 16'h7777;
      bus.in_pc_inc2 = 16'h0014;
      tick();
      idle();
      checks++;
      if (bus.count !== 2'd0 || bus.out_instr !== 16'h0800 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_full got c=%0d i=%h v=%b exp c=0 i=0800 v=0",
                            bus.count, bus.out_instr, bus.out_valid);
      end
      // flush with a push and pop that would both otherwise happen
      push(16'h7777, 16'h0020);
      bus.flush      = 1'b1;
      bus.out_ready  = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_instr   = 16'h8888;
      bus.in_pc_inc2 = 16'h0022;
      tick();
      idle();
      checks++;
      if (bus.count !== 2'd0 || bus.out_instr !== 16'h0800 || bus.out_pc_inc2 !== 16'h0000) begin
         errors++; $display("FAIL flush_pushpop got c=%0d i=%h pc=%h exp c=0 i=0800 pc=0000",
                            bus.count, bus.out_instr, bus.out_pc_inc2);
      end
      push(16'h9999, 16'h0030);
      checks++;
      if (bus.count !== 2'd1 || bus.out_instr !== 16'h9999 || bus.out_pc_inc2 !== 16'h0030) begin
         errors++; $display("FAIL flush_after got c=%0d %h/%h exp c=1 9999/0030",
                            bus.count, bus.out_instr, bus.out_pc_inc2);
      end
      bus.flush = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_halt();
      idle();
      // HALT encoding presented without in_valid must not latch
      bus.in_instr = 16'h0000;
      tick();
      checks++;
      if (bus.halt_seen !== 1'b0 || bus.count !== 2'd0) begin
         errors++; $display("FAIL halt_novalid got h=%b c=%0d exp h=0 c=0", bus.halt_seen, bus.count);
      end
      push(16'h0000, 16'h0040);
      checks++;
      if (bus.halt_seen !== 1'b1 || bus.in_ready !== 1'b0 || bus.count !== 2'd1 ||
          bus.out_instr !== 16'h0000) begin
         errors++; $display("FAIL halt_set got h=%b rdy=%b c=%0d i=%h exp h=1 rdy=0 c=1 i=0000",
                            bus.halt_seen, bus.in_ready, bus.count, bus.out_instr);
      end
      push(16'h3333, 16'h0042);
      push(16'h3333, 16'h0042);
      checks++;
      if (bus.count !== 2'd1 || bus.out_instr !== 16'h0000) begin
         errors++; $display("FAIL halt_block got c=%0d i=%h exp c=1 i=0000", bus.count, bus.out_instr);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++;
      if (bus.count !== 2'd0 || bus.out_instr !== 16'h0800 || bus.halt_seen !== 1'b1 ||
          bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL halt_drain got c=%0d i=%h h=%b rdy=%b exp c=0 i=0800 h=1 rdy=0",
                            bus.count, bus.out_instr, bus.halt_seen, bus.in_ready);
      end
      bus.flush = 1'b1;
      tick();
      idle();
      checks++;
      if (bus.halt_seen !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL halt_clear got h=%b rdy=%b exp h=0 rdy=1", bus.halt_seen, bus.in_ready);
      end
   endtask

   task automatic test_async_reset();
      idle();
      push(16'hAAAA, 16'h0050);
      push(16'hBBBB, 16'h0052);
      checks++;
      if (bus.count !== 2'd2) begin
         errors++; $display("FAIL arst_pre got c=%0d exp 2", bus.count);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_instr !== 16'h0800) begin
         errors++; $display("FAIL arst_now got c=%0d v=%b i=%h exp c=0 v=0 i=0800",
                            bus.count, bus.out_valid, bus.out_instr);
      end
      #1 rst = 1'b1;
      tick();
      push(16'hCCCC, 16'h0060);
      checks++;
      if (bus.count !== 2'd1 || bus.out_instr !== 16'hCCCC) begin
         errors++; $display("FAIL arst_after got c=%0d i=%h exp c=1 i=CCCC", bus.count, bus.out_instr);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_fill_drain();
      test_streaming();
      test_flush();
      test_halt();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
